// File: rtl/dtc_vote_pkg.sv
// Shared types and the vote helper for the dtc_label_vote temporal-vote stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dtc_vote_pkg;

    localparam int LABEL_W   = 3;
    localparam int CNT_MAX_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Strict majority 2*cnt > n; a tie votes 0. Operands are zero-extended by the caller.
    function automatic logic majority(input logic [CNT_MAX_W-1:0] cnt,
                                      input logic [CNT_MAX_W-1:0] n);
        return ({cnt, 1'b0} > {1'b0, n});
    endfunction

endpackage

// File: rtl/dtc_vote_bitctr.sv
// Per-label-bit vote counter with synchronous clear; exposes the post-increment count.
// Latency: count registers on the clock edge; cnt_nxt is combinational from inc.
// Backpressure: none, the parent gates inc with its accept.
module dtc_vote_bitctr
    import dtc_vote_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_nxt
);

    logic [CNT_W-1:0] cnt;

    assign cnt_nxt = cnt + CNT_W'(inc);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dtc_label_vote.sv
// Per-bit strict-majority vote over windows of WINDOW labels (early close on in_last); DTC_VOTE_COUNTS_EN adds out_counts.
// Latency: out_valid rises the cycle after the closing accept.
// Backpressure: in_ready=0 for the whole EMIT state; the result holds until out_ready.
module dtc_label_vote
    import dtc_vote_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [CNT_W-1:0]   out_n
`ifdef DTC_VOTE_COUNTS_EN
    ,
    output logic [LABEL_W*CNT_W-1:0] out_counts
`endif
);

    state_t             state, state_d;
    logic               rdy_q;
    logic               accept, close, done, clr;
    logic [CNT_W-1:0]   n_q, n_nxt;
    logic [CNT_W-1:0]   cnt_nx [LABEL_W];
    logic [LABEL_W-1:0] vote;
    logic [LABEL_W-1:0] label_q;
    logic [CNT_W-1:0]   out_n_q;

    assign accept = in_valid && rdy_q;
    assign n_nxt  = n_q + CNT_W'(1);
    assign close  = accept && (in_last || (n_nxt == CNT_W'(WINDOW)));
    assign done   = (state == EMIT) && out_ready;
    assign clr    = rst || done;

    for (genvar i = 0; i < LABEL_W; i++) begin : g_bit
        dtc_vote_bitctr #(.CNT_W(CNT_W)) u_ctr (
            .clk     (clk),
            .clr     (clr),
            .inc     (accept && in_label[i]),
            .cnt_nxt (cnt_nx[i])
        );
    end

    always_comb begin
        vote = '0;
        for (int i = 0; i < LABEL_W; i++) begin
            vote[i] = majority(CNT_MAX_W'(cnt_nx[i]), CNT_MAX_W'(n_nxt));
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ACCUM:   if (close) state_d = EMIT;
            EMIT:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_d;
        end
    end

    // in_ready comes from its own flop so it is low during reset and never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q   <= 1'b0;
            n_q     <= '0;
            label_q <= '0;
            out_n_q <= '0;
        end else begin
            rdy_q <= (state_d == ACCUM);
            if (done) begin
                n_q <= '0;
            end else if (accept) begin
                n_q <= n_nxt;
            end
            if (close) begin
                label_q <= vote;
                out_n_q <= n_nxt;
            end
        end
    end

`ifdef DTC_VOTE_COUNTS_EN
    logic [LABEL_W*CNT_W-1:0] counts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            counts_q <= '0;
        end else if (close) begin
            for (int i = 0; i < LABEL_W; i++) begin
                counts_q[i*CNT_W +: CNT_W] <= cnt_nx[i];
            end
        end
    end

    assign out_counts = counts_q;
`endif

    assign in_ready  = rdy_q;
    assign out_valid = (state == EMIT);
    assign out_label = label_q;
    assign out_n     = out_n_q;

endmodule

// File: doc/dtc_label_vote.md
# dtc_label_vote

Streaming temporal-vote stage placed directly downstream of a combinational decision-tree classifier. Accepts one 3-bit label vector per handshake, accumulates per-bit vote counts over a window of WINDOW samples (or fewer, if terminated early by in_last), and emits one strict-majority label vector per window. Used to suppress single-sample classification glitches before labels reach the system-level consumer.

## Interface
- WINDOW, 16: samples per full window; legal range 1..255.
- CNT_W, $clog2(WINDOW+1): width of the per-bit vote counters and of the sample counter.

- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  in_label is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_label  in  3  classifier output; each bit is an independent label.
- in_last  in  1  qualified by in_valid; closes the window early after this sample is counted.
- out_valid  out  1  out_label and out_n are valid.
- out_ready  in  1  downstream consumer accepts the result.
- out_label  out  3  voted label vector.
- out_n  out  CNT_W  number of samples in the emitted window (1..WINDOW).

## Operation
- FSM states: ACCUM and EMIT. Reset state is ACCUM.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - An accept occurs when in_valid && in_ready. On accept, each cnt[i] increments if in_label[i]=1, and n increments by 1.
  - If the accept is the WINDOW-th sample, or in_last=1, the block loads the result registers from the post-increment counts and moves to EMIT.
- Vote rule: out_label[i] = (2*cnt[i] > n), evaluated at CNT_W+1 bits. Ties resolve to 0. For example, with n=4, cnt=2 gives 0 and cnt=3 gives 1. out_n = n.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_label and out_n stay stable until out_ready=1.
  - On out_ready=1, all cnt[i] and n clear and the FSM returns to ACCUM.
- in_last with WINDOW=1 is redundant and harmless; the window still closes after one sample.
- Counters never exceed WINDOW, so no saturation logic is needed.
- rst in any state: FSM goes to ACCUM, all counters are cleared, and any partially accumulated or pending result is discarded.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 from the first cycle after rst deasserts. out_valid=0, out_label=3'b000, out_n=0.
- Latency: out_valid rises in the cycle after the closing accept.
- Throughput: one window per WINDOW+1 cycles at best. The EMIT cycle is a mandatory input bubble, because in_ready=0 there.
- out_ready may be held high continuously. In that case EMIT lasts exactly 1 cycle.
- in_label and in_last are ignored when in_valid=0. in_valid may be asserted while in_ready=0; no sample is taken in that case.
- No combinational path from out_ready to in_ready. in_ready is a registered function of the state.

## Configuration
- DTC_VOTE_COUNTS_EN
  - Defined: adds output port out_counts (3*CNT_W bits), holding the registered cnt[2:0] of the emitted window. Bit field i is [i*CNT_W +: CNT_W]. It is valid with out_valid and resets to 0.
  - Undefined: the port and its registers are absent. All other behaviour is identical.

## Structure
- Package dtc_vote_pkg:
  - LABEL_W=3.
  - State enum {ACCUM, EMIT}.
  - Vote helper function majority(cnt, n).
- Sub-module dtc_vote_bitctr: one per label bit.
  - Synchronous clear, increment-enable, CNT_W wide.
  - Instantiated LABEL_W times in a generate loop.

## Test plan
- WINDOW=4, inputs 3'b101, 3'b100, 3'b001, 3'b101 back-to-back with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_label=3'b101, out_n=4. The next cycle has in_ready=0.
- WINDOW=4, inputs 3'b011, 3'b010, 3'b001, 3'b000 -> out_label=3'b000 (bit0 and bit1 are 2/4 ties, bit2 is 0/4), out_n=4.
- WINDOW=4, 3'b111 then 3'b110 with in_last=1 on the second -> out_n=2, out_label=3'b110.
- out_ready held 0 for 5 cycles during EMIT, with in_valid=1 throughout -> in_ready=0 and outputs stable for all 5 cycles. No sample is lost or counted. The result is accepted on the cycle out_ready=1, and ACCUM resumes the next cycle.
- rst pulsed for 1 cycle after 2 accepts in ACCUM, then 4 samples of 3'b001 -> out_label=3'b001, out_n=4. No residue from before the reset.
- DTC_VOTE_COUNTS_EN defined, WINDOW=4, inputs 3'b111, 3'b011, 3'b001, 3'b000 -> out_counts fields {cnt2,cnt1,cnt0}={1,2,3}, out_label=3'b001.
